// File: rtl/dds_wave_meter_pkg.sv
// Shared constants for the DDS sample-stream meter: sample format and FSM state encodings.
package dds_wave_meter_pkg;

  localparam int unsigned DDS_DATA_W = 8;
  localparam int unsigned DDS_MID    = 2 ** (DDS_DATA_W - 1);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_MEAS = 1'b1;

endpackage

// File: rtl/dds_wave_meter_xdet.sv
// Hysteresis crossing detector: registered LO/HI comparator state and combinational rise flag.
module dds_wave_meter_xdet #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HYST   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              hi,
  output logic              rise
);

  localparam int unsigned        Mid  = 2 ** (DATA_W - 1);
  localparam logic [DATA_W-1:0] ThHi = DATA_W'(Mid + HYST);
  localparam logic [DATA_W-1:0] ThLo = DATA_W'(Mid - HYST);

  logic hi_q, hi_d;

  always_comb begin
    hi_d = hi_q;
    rise = 1'b0;
    if (din_vld) begin
      if (!hi_q && (din >= ThHi)) begin
        hi_d = 1'b1;
        rise = 1'b1;
      end else if (hi_q && (din <= ThLo)) begin
        hi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
    end
  end

  assign hi = hi_q;

endmodule

// File: rtl/dds_wave_meter.sv
// Measures averaged period and per-window peak max/min of a DDS sample stream.
module dds_wave_meter
  import dds_wave_meter_pkg::*;
#(
  parameter int unsigned DATA_W    = DDS_DATA_W,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned HYST      = 8,
  parameter int unsigned LOG2_NPER = 2,
  parameter int unsigned TIMEOUT   = 1048576
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] vmax,
  output logic [DATA_W-1:0] vmin,
  output logic              meas_vld,
  output logic              no_signal
);

  localparam int unsigned NPER = 2 ** LOG2_NPER;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [LOG2_NPER-1:0] ECNT_LAST = LOG2_NPER'(NPER - 1);
  localparam logic [TO_W-1:0]      TO_MAX    = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT - 1);

  logic              st_q, st_d;
  logic [CNT_W-1:0]  sum_q, sum_d;
  logic [LOG2_NPER-1:0] ecnt_q, ecnt_d;
  logic [DATA_W-1:0] trk_max_q, trk_max_d;
  logic [DATA_W-1:0] trk_min_q, trk_min_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [DATA_W-1:0] vmax_q, vmax_d;
  logic [DATA_W-1:0] vmin_q, vmin_d;
  logic              meas_vld_q, meas_vld_d;
  logic              no_signal_q, no_signal_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic              cmp_hi;
  logic              rise;
  logic [CNT_W-1:0]  sum_inc;
  logic [CNT_W:0]    sum_p1;

  dds_wave_meter_xdet #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_xdet (
    .clk     (clk),
    .rstn    (rstn),
    .din     (din),
    .din_vld (din_vld),
    .hi      (cmp_hi),
    .rise    (rise)
  );

  // Sum saturates; the window total is sum+1 because the closing edge sample belongs to it.
  assign sum_inc = (sum_q == {CNT_W{1'b1}}) ? sum_q : sum_q + 1'b1;
  assign sum_p1  = {1'b0, sum_q} + 1'b1;

  always_comb begin
    st_d        = st_q;
    sum_d       = sum_q;
    ecnt_d      = ecnt_q;
    trk_max_d   = trk_max_q;
    trk_min_d   = trk_min_q;
    period_d    = period_q;
    vmax_d      = vmax_q;
    vmin_d      = vmin_q;
    meas_vld_d  = 1'b0;
    no_signal_d = no_signal_q;
    to_d        = to_q;

    if (din_vld) begin
      if (rise) begin
        to_d = '0;
      end else if (to_q != TO_MAX) begin
        to_d = to_q + 1'b1;
      end

      case (st_q)
        ST_SYNC: begin
          if (rise) begin
            sum_d     = '0;
            ecnt_d    = '0;
            trk_max_d = din;
            trk_min_d = din;
            st_d      = ST_MEAS;
          end
        end
        default: begin
          if (rise && (ecnt_q == ECNT_LAST)) begin
            period_d    = CNT_W'(sum_p1 >> LOG2_NPER);
            vmax_d      = trk_max_q;
            vmin_d      = trk_min_q;
            meas_vld_d  = 1'b1;
            no_signal_d = 1'b0;
            sum_d       = '0;
            ecnt_d      = '0;
            trk_max_d   = din;
            trk_min_d   = din;
          end else begin
            sum_d = sum_inc;
            if (rise) begin
              ecnt_d = ecnt_q + 1'b1;
            end
            if (din > trk_max_q) begin
              trk_max_d = din;
            end
            if (din < trk_min_q) begin
              trk_min_d = din;
            end
          end
        end
      endcase

      // Timeout fires once, on the sample that brings the counter to TIMEOUT.
      if (!rise && (to_q == TO_LAST)) begin
        no_signal_d = 1'b1;
        st_d        = ST_SYNC;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q        <= ST_SYNC;
      sum_q       <= '0;
      ecnt_q      <= '0;
      trk_max_q   <= '0;
      trk_min_q   <= '0;
      period_q    <= '0;
      vmax_q      <= '0;
      vmin_q      <= '0;
      meas_vld_q  <= 1'b0;
      no_signal_q <= 1'b0;
      to_q        <= '0;
    end else begin
      st_q        <= st_d;
      sum_q       <= sum_d;
      ecnt_q      <= ecnt_d;
      trk_max_q   <= trk_max_d;
      trk_min_q   <= trk_min_d;
      period_q    <= period_d;
      vmax_q      <= vmax_d;
      vmin_q      <= vmin_d;
      meas_vld_q  <= meas_vld_d;
      no_signal_q <= no_signal_d;
      to_q        <= to_d;
    end
  end

  assign period    = period_q;
  assign vmax      = vmax_q;
  assign vmin      = vmin_q;
  assign meas_vld  = meas_vld_q;
  assign no_signal = no_signal_q;

endmodule
